gaussian_conv: RTL
==================

GAUSSIAN_CONV -- requirements
Module: gaussian_conv

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 512, meaning windows (output pixels) per image line.
REQ-002 SHALL have parameter ROUND_EN, default 1, meaning 1 = round-half-up before divide-by-16, 0 = truncate.
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port i_pixel_data  input  72  meaning 3x3 window from the line-buffer controller: byte k = bits[8k+7:8k], k=0..8; row = k/3, col = k%3.
REQ-006 SHALL have port i_pixel_data_valid  input  1  meaning i_pixel_data holds a valid window this cycle.
REQ-007 SHALL have port o_convolved_data  output  8  meaning blurred pixel.
REQ-008 SHALL have port o_convolved_data_valid  output  1  meaning o_convolved_data valid this cycle.
REQ-009 SHALL have port o_line_done  output  1  meaning one-cycle pulse coincident with the LINE_WIDTH-th valid output of a line.

Function
REQ-010 SHALL apply kernel weights 1 for k=0,2,6,8; 2 for k=1,3,5,7; 4 for k=4 (sum 16), implemented with shifts only, no multipliers.
REQ-011 SHALL compute the unsigned weighted sum in 12 bits (max 4080); no overflow possible.
REQ-012 SHALL output (sum+8)>>4 when ROUND_EN=1 (max 255, no saturation needed), else sum>>4.
REQ-013 SHALL be a 3-stage pipeline: S1 register nine weighted terms; S2 register 12-bit sum; S3 register rounded 8-bit result.
REQ-014 SHALL assert o_convolved_data_valid exactly 3 cycles after the i_pixel_data_valid cycle whose window it belongs to.
REQ-015 SHALL accept one window per cycle with no stalls; no backpressure input exists.
REQ-016 SHALL preserve valid gaps: invalid input cycles yield invalid output cycles 3 cycles later, in order.
REQ-017 SHALL hold o_convolved_data at its last value while o_convolved_data_valid is low.
REQ-018 SHALL count valid outputs in a clog2(LINE_WIDTH)-bit counter; increment on each o_convolved_data_valid.
REQ-019 SHALL pulse o_line_done for one cycle when the counter equals LINE_WIDTH-1 and output is valid, and wrap counter to 0 on that cycle.
REQ-020 SHALL not advance the counter on invalid cycles; partial lines persist across gaps of any length.
REQ-021 SHALL ignore i_pixel_data content when i_pixel_data_valid is low (stage registers may update, valid bits must not).

Reset
REQ-022 SHALL, on i_rst_n low, immediately clear all pipeline valid bits, o_convolved_data_valid=0, o_line_done=0, o_convolved_data=0, line counter=0.
REQ-023 SHALL discard windows in flight when reset asserts mid-pipeline; no valid output appears for them after release.
REQ-024 SHALL accept a valid window on the first rising edge after i_rst_n deasserts; its output appears 3 cycles later.

Structure
REQ-025 SHALL place kernel weight constants, SUM_W=12 and the default LINE_WIDTH in shared package gaussian_pkg.
REQ-026 SHALL be a single module; no sub-module is warranted (adder tree and counter inline).
REQ-027 SHALL connect directly to the line-buffer controller's 72-bit window and valid outputs.

Verification
REQ-028 SHALL cover: all nine bytes 0xFF, one valid -> o_convolved_data=0xFF, valid high exactly 3 cycles later.
REQ-029 SHALL cover: only byte 4 = 0x10, others 0 -> output 0x04; only byte 0 = 0xFF -> 0x10 (ROUND_EN=1), 0x0F (ROUND_EN=0).
REQ-030 SHALL cover: 512 back-to-back valid windows -> 512 consecutive valid outputs, o_line_done high only on the 512th, counter back to 0.
REQ-031 SHALL cover: valid pattern 1,0,0,1,1 with distinct windows -> identical valid pattern and matching results, shifted 3 cycles.
REQ-032 SHALL cover: i_rst_n pulsed low with 2 windows in flight -> outputs zero immediately, no valid pulses afterwards until new input.
REQ-033 SHALL cover: 300 valids, 1000-cycle gap, 212 valids -> o_line_done on the 512th output only.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared constants for the 3x3 Gaussian blur: kernel weights as shift amounts,
// accumulator width and default line length.
package gaussian_pkg;

  localparam int PIX_W          = 8;
  localparam int KTAPS          = 9;
  localparam int WIN_W          = PIX_W * KTAPS;
  localparam int SUM_W          = 12;
  localparam int LINE_WIDTH_DEF = 512;

  // Weight of tap k is (1 << K_SHIFT[k]): corners 1, edges 2, centre 4 (sum 16).
  localparam int K_SHIFT [KTAPS] = '{0, 1, 0, 1, 2, 1, 0, 1, 0};

endpackage

// File: rtl/gaussian_conv.sv
// 3x3 Gaussian blur (1-2-1 / 2-4-2 / 1-2-1, divide by 16) over windows from the
// line-buffer controller, with a per-line output counter and line-done pulse.
module gaussian_conv
  import gaussian_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter bit ROUND_EN   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIN_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [PIX_W-1:0] o_convolved_data,
  output logic             o_convolved_data_valid,
  output logic             o_line_done
);

  localparam int              CNT_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_WIDTH - 1);

  // Sum max is 4080, so +8 still fits SUM_W and the quotient always fits a pixel.
  function automatic logic [PIX_W-1:0] round_div16(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] biased;
    biased = ROUND_EN ? (sum + SUM_W'(8)) : sum;
    return biased[SUM_W-1:4];
  endfunction

  logic [SUM_W-1:0] terms_p0 [KTAPS];
  logic             vld_p0;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] sum_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] line_cnt;

  // Stage 1: weighted terms
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < KTAPS; k++) begin
      terms_p0[k] <= SUM_W'(i_pixel_data[PIX_W*k +: PIX_W]) << K_SHIFT[k];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < KTAPS; k++) begin
      sum_c = sum_c + terms_p0[k];
    end
  end

  // Stage 2: 12-bit sum
  always_ff @(posedge i_clk) begin
    sum_p1 <= sum_c;
  end

  // Stage 3: rounded output, valid chain and line counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0                 <= 1'b0;
      vld_p1                 <= 1'b0;
      o_convolved_data_valid <= 1'b0;
      o_line_done            <= 1'b0;
      o_convolved_data       <= '0;
      line_cnt               <= '0;
    end else begin
      vld_p0                 <= i_pixel_data_valid;
      vld_p1                 <= vld_p0;
      o_convolved_data_valid <= vld_p1;
      o_line_done            <= 1'b0;
      if (vld_p1) begin
        o_convolved_data <= round_div16(sum_p1);
        if (line_cnt == LAST) begin
          line_cnt    <= '0;
          o_line_done <= 1'b1;
        end else begin
          line_cnt <= line_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
